fetch_ifid: RTL
===============

// Module: fetch_ifid
// PURPOSE
//  LEGv8 fetch stage plus IF/ID pipeline register. Owns the PC and fetches from a
//  handshaked instruction memory (variable latency, >=1 cycle).
//  Presents {pc_d, instr_d, valid_d} to decode, which takes Op = instr_d[31:21].
//  Handles decode stall, taken-branch redirect with in-flight discard, and bubble
//  insertion (instr_d = 0, which decodes to all-zero controls).
// PARAMETERS
//  RESET_PC  64'h0  PC loaded on reset; bits [1:0] must be 0
//  PC_W      64     PC / address width
// PORTS
//  clk          in   1     clock, all state on rising edge
//  reset        in   1     asynchronous, active-high reset
//  imem_req     out  1     fetch request; held with stable imem_addr until imem_ack
//  imem_addr    out  PC_W  fetch address (= pc_f)
//  imem_ack     in   1     1-cycle pulse; imem_rdata valid in the same cycle
//  imem_rdata   in   32    fetched instruction
//  stall_d      in   1     decode cannot accept; IF/ID holds its contents
//  redirect     in   1     taken branch; flush IF/ID and refetch from redirect_pc
//  redirect_pc  in   PC_W  branch target; bits [1:0] forced to 0
//  pc_d         out  PC_W  IF/ID: PC of instr_d
//  instr_d      out  32    IF/ID: instruction (0 when bubble)
//  valid_d      out  1     IF/ID: instr_d is a real instruction
// BEHAVIOUR
//  Reset (async): state=IDLE, pc_f=RESET_PC, pc_d=0, instr_d=0, valid_d=0,
//   hold regs=0; imem_req=0. IDLE->FETCH on the first clock after reset drops.
//  imem_req=1 in FETCH and DISCARD only (registered state decode). imem_addr=pc_f.
//  States (priority: reset > redirect > stall > normal):
//   FETCH, ack & !redirect & !stall_d: IF/ID<={pc_f,rdata,1}; pc_f+=4; stay.
//   FETCH, ack & !redirect & stall_d: hold<={pc_f,rdata}; pc_f+=4; IF/ID kept; ->HOLD.
//   FETCH, !ack & !redirect: pc_f kept; IF/ID<=bubble if !stall_d else kept.
//   FETCH, redirect & ack: drop rdata; pc_f<=redirect_pc; IF/ID<=bubble; stay FETCH.
//   FETCH, redirect & !ack: pc_f<=redirect_pc; IF/ID<=bubble; ->DISCARD.
//    imem_addr stays on the old request address (saved copy) until its ack.
//   DISCARD: req held on old addr; on ack drop rdata ->FETCH (new pc_f).
//    Redirect here updates pc_f only. IF/ID<=bubble unless stall_d.
//   HOLD: req=0. !stall_d: IF/ID<={hold,1} ->FETCH. redirect: drop hold,
//    pc_f<=redirect_pc, IF/ID<=bubble ->FETCH.
//  Bubble = {pc_d=0, instr_d=0, valid_d=0}. Redirect flushes IF/ID even if stall_d=1.
//  Latency: ack in cycle N -> instr_d valid after edge N (1 cycle); throughput 1/cycle
//   when imem acks every cycle.
//  pc_f+4 wraps modulo 2^PC_W. No instruction dropped or duplicated except on redirect.
//  imem_ack while imem_req=0 is a protocol error; it is ignored.
//  Reset mid-request: state->IDLE; any later ack before req is reasserted is ignored.
// TESTING
//  1 Reset, RESET_PC=0x100, ack every cycle -> instr_d sequence of pc_d=0x100,0x104,0x108;
//    valid_d=1 from the 2nd cycle after reset release.
//  2 Ack 3 cycles after req -> imem_addr stable 3 cycles; 2 bubbles then instr at 0x100.
//  3 stall_d=1 for 4 cycles while ack arrives -> IF/ID frozen; HOLD; on release
//    held instr appears next cycle, no loss or duplicate.
//  4 redirect=1, redirect_pc=0x2003 with ack same cycle -> rdata dropped, next
//    imem_addr=0x2000, instr_d=0, valid_d=0.
//  5 redirect during outstanding req (ack 2 cycles later) -> DISCARD; old data dropped;
//    next req addr=0x2000.
//  6 pc_f=0xFFFF_FFFF_FFFF_FFFC, ack -> next imem_addr=0; reset mid-request -> req=0.

Source files
------------

// File: rtl/fetch_ifid_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_ifid_if #(
  parameter int PC_W = 64
);
  // Handshake: the master raises imem_req with imem_addr and holds both stable
  // until the slave pulses imem_ack for exactly one cycle, with imem_rdata valid
  // in that same cycle. An ack while imem_req is low carries no meaning.
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_ifid.sv
// LEGv8 fetch stage with IF/ID pipeline register: owns the PC, fetches over a
// variable-latency handshake, and handles decode stall, redirect and bubbles.
module fetch_ifid #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  fetch_ifid_if.master     imem,
  input  logic             stall_d,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  pc_d,
  output logic [31:0]      instr_d,
  output logic             valid_d,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc_f;
  logic [PC_W-1:0] disc_addr;
  logic [PC_W-1:0] hold_pc;
  logic [31:0]     hold_instr;
  logic [PC_W-1:0] target;

  assign target         = {redirect_pc[PC_W-1:2], 2'b00};
  assign imem.imem_req  = (state == S_FETCH) || (state == S_DISCARD);
  // An abandoned request keeps its original address until the memory answers it.
  assign imem.imem_addr = (state == S_DISCARD) ? disc_addr : pc_f;
  assign dbg_state      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc_f       <= RESET_PC;
      disc_addr  <= '0;
      hold_pc    <= '0;
      hold_instr <= '0;
      pc_d       <= '0;
      instr_d    <= '0;
      valid_d    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;

        S_FETCH: begin
          if (redirect) begin
            pc_f    <= target;
            pc_d    <= '0;
            instr_d <= '0;
            valid_d <= 1'b0;
            if (!imem.imem_ack) begin
              disc_addr <= pc_f;
              state     <= S_DISCARD;
            end
          end else if (imem.imem_ack) begin
            pc_f <= pc_f + PC_W'(4);
            if (stall_d) begin
              hold_pc    <= pc_f;
              hold_instr <= imem.imem_rdata;
              state      <= S_HOLD;
            end else begin
              pc_d    <= pc_f;
              instr_d <= imem.imem_rdata;
              valid_d <= 1'b1;
            end
          end else if (!stall_d) begin
            pc_d    <= '0;
            instr_d <= '0;
            valid_d <= 1'b0;
          end
        end

        S_DISCARD: begin
          if (redirect) pc_f <= target;
          if (redirect || !stall_d) begin
            pc_d    <= '0;
            instr_d <= '0;
            valid_d <= 1'b0;
          end
          if (imem.imem_ack) state <= S_FETCH;
        end

        S_HOLD: begin
          // The held instruction is already fetched; a redirect simply discards it.
          if (redirect) begin
            pc_f    <= target;
            pc_d    <= '0;
            instr_d <= '0;
            valid_d <= 1'b0;
            state   <= S_FETCH;
          end else if (!stall_d) begin
            pc_d    <= hold_pc;
            instr_d <= hold_instr;
            valid_d <= 1'b1;
            state   <= S_FETCH;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
